wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Writeback arbiter: LSU/MDU/ALU share one register-file write port, with starvation boost.
// Optional operand scoreboard is built when WB_SCOREBOARD_EN is defined.
module wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_ready,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_wdata,
  output logic        alu_ready,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
`ifdef WB_SCOREBOARD_EN
  input  logic        alloc_en,
  input  logic [4:0]  alloc_rd,
  input  logic        flush,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  output logic        rs1_busy,
  output logic        rs2_busy,
`endif
  output logic        wreg_en,
  output logic [4:0]  wreg_index,
  output logic [31:0] wdata
);

  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  // Requester slots in base-priority order: 0 = LSU, 1 = MDU, 2 = ALU.
  logic [2:0]    vld;
  logic [2:0]    boost;
  logic [2:0]    gnt;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic          xfer;
  logic [4:0]    sel_rd;
  logic [31:0]   sel_data;
  logic          wreg_en_d;
  logic [4:0]    wreg_index_d;
  logic [31:0]   wdata_d;
  logic          wreg_en_q;
  logic [4:0]    wreg_index_q;
  logic [31:0]   wdata_q;

  assign vld = {alu_valid, mdu_valid, lsu_valid};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      boost[i] = vld[i] && (cnt_q[i] == LIMIT);
    end
    gnt = 3'b000;
    if (!reset)        gnt = 3'b000;
    else if (boost[0]) gnt = 3'b001;
    else if (boost[1]) gnt = 3'b010;
    else if (boost[2]) gnt = 3'b100;
    else if (vld[0])   gnt = 3'b001;
    else if (vld[1])   gnt = 3'b010;
    else if (vld[2])   gnt = 3'b100;
  end

  assign lsu_ready = gnt[0];
  assign mdu_ready = gnt[1];
  assign alu_ready = gnt[2];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (vld[i] && !gnt[i]) begin
        cnt_d[i] = (cnt_q[i] == LIMIT) ? cnt_q[i] : cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    xfer     = |gnt;
    sel_rd   = '0;
    sel_data = '0;
    unique case (gnt)
      3'b001:  begin sel_rd = lsu_rd; sel_data = lsu_wdata; end
      3'b010:  begin sel_rd = mdu_rd; sel_data = mdu_wdata; end
      3'b100:  begin sel_rd = alu_rd; sel_data = alu_wdata; end
      default: ;
    endcase
    // An rd=0 transfer is consumed but never writes the register file.
    wreg_en_d    = xfer && (sel_rd != 5'd0);
    wreg_index_d = xfer ? sel_rd : wreg_index_q;
    wdata_d      = xfer ? sel_data : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wreg_en_q    <= 1'b0;
      wreg_index_q <= '0;
      wdata_q      <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      wreg_en_q    <= wreg_en_d;
      wreg_index_q <= wreg_index_d;
      wdata_q      <= wdata_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign wreg_en    = wreg_en_q;
  assign wreg_index = wreg_index_q;
  assign wdata      = wdata_q;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q;
  logic [31:0] busy_d;

  // Clear from the registered write first so a same-index alloc wins.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wreg_en_q) busy_d[wreg_index_q] = 1'b0;
      if (alloc_en && (alloc_rd != 5'd0)) busy_d[alloc_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // The register file forwards the in-flight write, so that index reads as ready.
  assign rs1_busy = (rs1_index != 5'd0) && !(wreg_en_q && (wreg_index_q == rs1_index))
                    && busy_q[rs1_index];
  assign rs2_busy = (rs2_index != 5'd0) && !(wreg_en_q && (wreg_index_q == rs2_index))
                    && busy_q[rs2_index];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v [3];
  logic [4:0]  rd [3];
  logic [31:0] wd [3];
  logic        lsu_ready, mdu_ready, alu_ready;
  logic        wreg_en;
  logic [4:0]  wreg_index;
  logic [31:0] wdata;
`ifdef WB_SCOREBOARD_EN
  logic        alloc_en, flush;
  logic [4:0]  alloc_rd, rs1_index, rs2_index;
  logic        rs1_busy, rs2_busy;
`endif

  always #5 clk = ~clk;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(rst_n),
    .lsu_valid(v[0]), .lsu_rd(rd[0]), .lsu_wdata(wd[0]), .lsu_ready(lsu_ready),
    .alu_valid(v[2]), .alu_rd(rd[2]), .alu_wdata(wd[2]), .alu_ready(alu_ready),
    .mdu_valid(v[1]), .mdu_rd(rd[1]), .mdu_wdata(wd[1]), .mdu_ready(mdu_ready),
`ifdef WB_SCOREBOARD_EN
    .alloc_en(alloc_en), .alloc_rd(alloc_rd), .flush(flush),
    .rs1_index(rs1_index), .rs2_index(rs2_index),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`endif
    .wreg_en(wreg_en), .wreg_index(wreg_index), .wdata(wdata)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: wait counts per requester, expected output register, busy set.
  int          mc [3];
  bit          m_en;
  logic [4:0]  m_idx;
  logic [31:0] m_data;
  bit          m_known;
  bit [31:0]   mb;
  int          last_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Boosted requesters first, then plain valids, each scanned in LSU, MDU, ALU order.
  function automatic int pick();
    if (!rst_n) return -1;
    for (int i = 0; i < 3; i++) if (v[i] && mc[i] == LIMIT) return i;
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit rs_exp(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
    if (m_en && m_idx == idx) return 1'b0;
    return mb[idx];
  endfunction

  task automatic run_cycle();
    int g;
    logic [2:0] r;
    @(negedge clk);
    g = pick();
    r = {alu_ready, mdu_ready, lsu_ready};
    for (int i = 0; i < 3; i++) check($sformatf("ready[%0d]", i), 32'(r[i]), 32'(g == i));
    check("wreg_en", 32'(wreg_en), 32'(m_en));
    if (m_known) begin
      check("wreg_index", 32'(wreg_index), 32'(m_idx));
      check("wdata", wdata, m_data);
    end
`ifdef WB_SCOREBOARD_EN
    check("rs1_busy", 32'(rs1_busy), 32'(rs_exp(rs1_index)));
    check("rs2_busy", 32'(rs2_busy), 32'(rs_exp(rs2_index)));
`endif
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) mc[i] = 0;
      m_en = 0; m_idx = '0; m_data = '0; m_known = 1; mb = '0;
    end else begin
`ifdef WB_SCOREBOARD_EN
      if (flush) mb = '0;
      else begin
        if (m_en) mb[m_idx] = 1'b0;
        if (alloc_en && alloc_rd != 5'd0) mb[alloc_rd] = 1'b1;
      end
`endif
      for (int i = 0; i < 3; i++)
        mc[i] = (v[i] && g != i) ? ((mc[i] < LIMIT) ? mc[i] + 1 : LIMIT) : 0;
      if (g >= 0) begin
        m_en = (rd[g] != 5'd0); m_idx = rd[g]; m_data = wd[g]; m_known = (rd[g] != 5'd0);
      end else begin
        m_en = 0;
      end
    end
    last_g = g;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin v[i] = 0; rd[i] = '0; wd[i] = '0; end
`ifdef WB_SCOREBOARD_EN
    alloc_en = 0; alloc_rd = '0; flush = 0; rs1_index = '0; rs2_index = '0;
`endif
  endtask

  int alu_c;
  int gseq [3];

  initial begin
    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) mc[i] = 0;
    m_en = 0; m_idx = '0; m_data = '0; m_known = 1; mb = '0; last_g = -1;
    repeat (2) @(posedge clk);
    #1;
    // Requests pending during reset must not be granted.
    for (int i = 0; i < 3; i++) begin v[i] = 1; rd[i] = 5'(i + 1); wd[i] = 32'(i) + 32'h100; end
    run_cycle();
    check("rst_wreg_en", 32'(wreg_en), 32'd0);
    check("rst_wreg_index", 32'(wreg_index), 32'd0);
    check("rst_wdata", wdata, 32'd0);
    rst_n = 1;
    idle_inputs();
    run_cycle();

    // All three valid, held until granted.
    v[0] = 1; rd[0] = 5'd5; wd[0] = 32'h1111_0005;
    v[1] = 1; rd[1] = 5'd6; wd[1] = 32'h2222_0006;
    v[2] = 1; rd[2] = 5'd7; wd[2] = 32'h3333_0007;
    for (int c = 0; c < 3; c++) begin
      run_cycle();
      gseq[c] = last_g;
      if (last_g >= 0) v[last_g] = 0;
      check($sformatf("hold_idx_c%0d", c + 1), 32'(wreg_index), 32'(5 + c));
    end
    check("hold_g0", 32'(gseq[0]), 32'd0);
    check("hold_g1", 32'(gseq[1]), 32'd1);
    check("hold_g2", 32'(gseq[2]), 32'd2);
    run_cycle();
    check("idle_hold_idx", 32'(wreg_index), 32'd7);

    // Starvation: LSU streams, ALU waits until its counter saturates.
    alu_c = -1;
    v[0] = 1; v[2] = 1; rd[2] = 5'd12; wd[2] = 32'hA1A1_0012;
    for (int c = 0; c < 7; c++) begin
      rd[0] = 5'(1 + c); wd[0] = $urandom;
      run_cycle();
      if (last_g == 2 && alu_c < 0) begin alu_c = c; v[2] = 0; end
    end
    check("starve_cycle", 32'(alu_c), 32'd4);
    idle_inputs();

    // rd=0 transfer is accepted but not written.
    v[2] = 1; rd[2] = 5'd0; wd[2] = 32'hDEADBEEF;
    run_cycle();
    check("rd0_ready", 32'(last_g), 32'd2);
    v[2] = 0;
    run_cycle();
    check("rd0_wreg_en", 32'(wreg_en), 32'd0);

    // Reset mid-wait clears the MDU counter; MDU wins right after release.
    v[0] = 1; rd[0] = 5'd1; v[1] = 1; rd[1] = 5'd2; wd[1] = 32'h0BAD_F00D;
    repeat (3) run_cycle();
    v[0] = 0; rst_n = 0;
    run_cycle();
    check("rst_mdu_grant", 32'(last_g), 32'hFFFF_FFFF);
    rst_n = 1;
    check("post_rst_en", 32'(wreg_en), 32'd0);
    run_cycle();
    check("post_rst_grant", 32'(last_g), 32'd1);
    idle_inputs();
    run_cycle();

`ifdef WB_SCOREBOARD_EN
    alloc_en = 1; alloc_rd = 5'd3;
    run_cycle();
    alloc_en = 0; rs1_index = 5'd3;
    check("sb_busy3", 32'(rs1_busy), 32'd1);
    v[0] = 1; rd[0] = 5'd3; wd[0] = 32'h33;
    run_cycle();
    v[0] = 0;
    run_cycle();
    check("sb_clear3", 32'(rs1_busy), 32'd0);
    v[0] = 1; rd[0] = 5'd9; wd[0] = 32'h99;
    run_cycle();
    v[0] = 0; alloc_en = 1; alloc_rd = 5'd9; rs1_index = 5'd9;
    run_cycle();
    alloc_en = 0;
    check("sb_alloc_wins", 32'(rs1_busy), 32'd1);
    flush = 1; alloc_en = 1; alloc_rd = 5'd10; rs2_index = 5'd10;
    run_cycle();
    flush = 0; alloc_en = 0;
    check("sb_flush9", 32'(rs1_busy), 32'd0);
    check("sb_flush10", 32'(rs2_busy), 32'd0);
    idle_inputs();
`endif

    // Randomized traffic, including occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst_n = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 3; i++) begin
        v[i]  = ($urandom_range(0, 9) < 6);
        rd[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wd[i] = $urandom;
      end
`ifdef WB_SCOREBOARD_EN
      alloc_en  = $urandom_range(0, 1);
      alloc_rd  = 5'($urandom_range(0, 31));
      flush     = ($urandom_range(0, 29) == 0);
      rs1_index = ($urandom_range(0, 1) != 0) ? m_idx : 5'($urandom_range(0, 31));
      rs2_index = 5'($urandom_range(0, 31));
`endif
      run_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
